// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard/control unit.
package pipeline_ctrl_pkg;

   // EX-stage operand forwarding selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // ResultSrc encodings of the execute stage
   localparam logic [1:0] RESULT_ALU  = 2'b00;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [1:0] RESULT_PC4  = 2'b10;

   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // Memory stage wins over writeback when both hold the same destination
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       wr_m,
      input logic [4:0] rd_w,
      input logic       wr_w
   );
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Combinational operand-forwarding comparators for the execute stage.
module forward_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   // Select forwarding source per operand
   always_comb begin
      fwd_a = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      fwd_b = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core, with a data-memory
// wait FSM, wait timeout flag and saturating performance counters.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter logic [1:0]  LOAD_SRC    = RESULT_LOAD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic [1:0]       ResultSrcE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             CntClr,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount,
   output logic             MemErr
);

   localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ERR = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lw_stall;
   logic              mem_stall;
   logic              redirect;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   forward_unit u_forward_unit (
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b)
   );

   // Hazard detection and prioritised stall/flush controls, all held low in reset
   always_comb begin
      lw_stall  = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
      mem_stall = MemReqM && !MemReadyM;
      redirect  = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      if (rst) begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         if (mem_stall) begin
            // EX is frozen, so a pending PCSrcE is simply taken later
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            redirect = 1'b1;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
         end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // Memory wait FSM next-state
   always_comb begin
      state_next = state;
      case (state)
         RUN:      if (mem_stall) state_next = MEM_WAIT;
         MEM_WAIT: if (!MemReqM || MemReadyM) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   // Memory wait FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_next;
   end

   // Wait-cycle counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         MemErr   <= 1'b0;
      end else begin
         // Held at zero in RUN so the count starts fresh on every MEM_WAIT entry
         if (state == RUN)
            wait_cnt <= '0;
         else if (mem_stall && (wait_cnt != WAIT_MAX))
            wait_cnt <= wait_cnt + 1'b1;
         if ((state == MEM_WAIT) && mem_stall && (wait_cnt == WAIT_ERR))
            MemErr <= 1'b1;
      end
   end

   // Saturating performance counters, clear has priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else if (CntClr) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
         if (redirect && (FlushCount != '1))
            FlushCount <= FlushCount + 1'b1;
      end
   end

endmodule
